// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcode/function encodings,
// the control FSM state type and immediate extension helpers.
package alu_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    // Extension helpers return 64 bits; callers size-cast to the datapath width
    // (signed cast for sext16 so the sign survives any width).
    function automatic logic [63:0] sext16(input logic [15:0] v);
        return {{48{v[15]}}, v};
    endfunction

    function automatic logic [63:0] zext16(input logic [15:0] v);
        return {48'b0, v};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one step per cycle for W cycles, with sign
// fix-up and an immediate finish on divide-by-zero.
module muldiv_iter #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         is_div,
    input  logic         is_signed,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] hi_res,
    output logic [W-1:0] lo_res
);

    localparam int unsigned CW = $clog2(W);

    // hi_q/lo_q hold {accumulator, multiplier} for mul and {remainder, quotient} for div
    logic          busy_q, div_q, negp_q, negr_q, bzero_q;
    logic [W-1:0]  hi_q, lo_q, b_q, a_q;
    logic [CW-1:0] cnt_q;

    logic          a_neg, b_neg;
    logic [W-1:0]  a_mag, b_mag;
    logic [W-1:0]  hi_n, lo_n;
    logic [W:0]    mul_sum, rsh, diff;
    logic          ge;
    logic [2*W-1:0] prod, prod_f;

    // Operand magnitudes taken at start
    always_comb begin
        a_neg = is_signed & a[W-1];
        b_neg = is_signed & b[W-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // One iteration step plus final sign fix-up of the post-step values
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rsh     = {hi_q, lo_q[W-1]};
        diff    = rsh - {1'b0, b_q};
        ge      = ~diff[W];
        if (div_q) begin
            hi_n = ge ? diff[W-1:0] : rsh[W-1:0];
            lo_n = {lo_q[W-2:0], ge};
        end else begin
            hi_n = mul_sum[W:1];
            lo_n = {mul_sum[0], lo_q[W-1:1]};
        end
        prod   = {hi_n, lo_n};
        prod_f = negp_q ? (~prod + 1'b1) : prod;
        if (!div_q) begin
            hi_res = prod_f[2*W-1:W];
            lo_res = prod_f[W-1:0];
        end else if (bzero_q) begin
            hi_res = a_q;
            lo_res = '1;
        end else begin
            hi_res = negr_q ? (~hi_n + 1'b1) : hi_n;
            lo_res = negp_q ? (~lo_n + 1'b1) : lo_n;
        end
    end

    assign done = busy_q & ((div_q & bzero_q) | (cnt_q == CW'(W - 1)));

    // Iteration state: load on start, step while busy, drop busy when done
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q  <= 1'b0;
            div_q   <= 1'b0;
            negp_q  <= 1'b0;
            negr_q  <= 1'b0;
            bzero_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            busy_q  <= 1'b1;
            div_q   <= is_div;
            negp_q  <= a_neg ^ b_neg;
            negr_q  <= a_neg;
            bzero_q <= (b == '0);
            hi_q    <= '0;
            lo_q    <= a_mag;
            b_q     <= b_mag;
            a_q     <= a;
            cnt_q   <= '0;
        end else if (busy_q) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Registered execute-stage ALU with iterative multiply/divide and HI/LO.
// Optional build macro: OVERFLOW_TRAP_EN adds ovf_trap and suppresses
// writeback on signed overflow of add/sub/addi.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned W   = 32,
    parameter int unsigned SHW = $clog2(W)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [5:0]     opcode,
    input  logic [5:0]     func,
    input  logic [SHW-1:0] shamt,
    input  logic [15:0]    immediate,
    input  logic [W-1:0]   pc,
    input  logic [W-1:0]   d1,
    input  logic [W-1:0]   d2,
    input  logic [7:0]     control_EX,
    output logic           out_valid,
    output logic [W-1:0]   outd1,
    output logic [W-1:0]   outd2,
    output logic [7:0]     control_ALU,
    output logic [5:0]     opcode_mem,
    output logic [W-1:0]   hi,
    output logic [W-1:0]   lo
`ifdef OVERFLOW_TRAP_EN
    ,
    output logic           ovf_trap
`endif
);

    state_t       state_q, state_d;
    logic         accept, is_md, md_start, md_done;
    logic [W-1:0] md_hi, md_lo;
    logic [W-1:0] imm_s, imm_z, add_sum, sub_diff, addi_sum;
    logic [W-1:0] res1, res2;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] outd1_q, outd1_d, outd2_q, outd2_d, hi_q, hi_d, lo_q, lo_d;
    logic [7:0]   ctrl_q, ctrl_d, ctrl_cap_q;
    logic [5:0]   opmem_q, opmem_d, op_cap_q;
    logic [W-1:0] d1_cap_q;
`ifdef OVERFLOW_TRAP_EN
    logic         ovf, ovf_q, ovf_d;
`endif

    assign imm_s    = W'(signed'(sext16(immediate)));
    assign imm_z    = W'(zext16(immediate));
    assign add_sum  = d1 + d2;
    assign sub_diff = d1 - d2;
    assign addi_sum = d1 + imm_s;

    assign accept   = in_valid & in_ready;
    assign is_md    = (opcode == OP_RTYPE) &&
                      ((func == FN_MULT) || (func == FN_MULTU) ||
                       (func == FN_DIV)  || (func == FN_DIVU));
    assign md_start = accept & is_md;

    muldiv_iter #(
        .W (W)
    ) u_muldiv_iter (
        .clock     (clock),
        .reset     (reset),
        .start     (md_start),
        .is_div    (func[1]),
        .is_signed (~func[0]),
        .a         (d1),
        .b         (d2),
        .done      (md_done),
        .hi_res    (md_hi),
        .lo_res    (md_lo)
    );

    // Single-cycle result decode; unknown encodings pass d1/d2 through
    always_comb begin
        res1 = d1;
        res2 = d2;
`ifdef OVERFLOW_TRAP_EN
        ovf  = 1'b0;
`endif
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_SLL: begin
                        if (shamt == '0) begin
                            res1 = '0;
                            res2 = '0;
                        end else begin
                            res2 = d2 << shamt;
                        end
                    end
                    FN_SRL:  res2 = d2 >> shamt;
                    FN_SRA:  res2 = $signed(d2) >>> shamt;
                    FN_SLLV: res2 = d2 << d1[SHW-1:0];
                    FN_SRLV: res2 = d2 >> d1[SHW-1:0];
                    FN_SRAV: res2 = $signed(d2) >>> d1[SHW-1:0];
                    FN_MFHI: res2 = hi_q;
                    FN_MFLO: res2 = lo_q;
                    FN_ADD: begin
                        res2 = add_sum;
`ifdef OVERFLOW_TRAP_EN
                        ovf  = (d1[W-1] == d2[W-1]) && (add_sum[W-1] != d1[W-1]);
`endif
                    end
                    FN_ADDU: res2 = add_sum;
                    FN_SUB: begin
                        res2 = sub_diff;
`ifdef OVERFLOW_TRAP_EN
                        ovf  = (d1[W-1] != d2[W-1]) && (sub_diff[W-1] != d1[W-1]);
`endif
                    end
                    FN_SUBU: res2 = sub_diff;
                    FN_AND:  res2 = d1 & d2;
                    FN_OR:   res2 = d1 | d2;
                    FN_XOR:  res2 = d1 ^ d2;
                    FN_NOR:  res2 = ~(d1 | d2);
                    FN_SLT:  res2 = W'($signed(d1) < $signed(d2));
                    FN_SLTU: res2 = W'(d1 < d2);
                    default: ;
                endcase
            end
            OP_ADDI: begin
                res2 = addi_sum;
`ifdef OVERFLOW_TRAP_EN
                ovf  = (d1[W-1] == imm_s[W-1]) && (addi_sum[W-1] != d1[W-1]);
`endif
            end
            OP_ADDIU:     res2 = addi_sum;
            OP_SLTI:      res2 = W'($signed(d1) < $signed(imm_s));
            OP_SLTIU:     res2 = W'(d1 < imm_s);
            OP_ANDI:      res2 = d1 & imm_z;
            OP_ORI:       res2 = d1 | imm_z;
            OP_XORI:      res2 = d1 ^ imm_z;
            OP_LUI:       res2 = W'({immediate, 16'b0});
            OP_LW, OP_SW: begin
                res2 = addi_sum;
                res1 = d2;
            end
            OP_JAL:       res2 = pc + W'(4);
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (md_start) state_d = func[1] ? DIV : MUL;
            MUL,
            DIV:     if (md_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and next values of the registered result path
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid_d = 1'b0;
        outd1_d     = outd1_q;
        outd2_d     = outd2_q;
        ctrl_d      = ctrl_q;
        opmem_d     = opmem_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
`ifdef OVERFLOW_TRAP_EN
        ovf_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept && !is_md) begin
                    out_valid_d = 1'b1;
                    outd1_d     = res1;
                    outd2_d     = res2;
                    ctrl_d      = control_EX;
                    opmem_d     = opcode;
`ifdef OVERFLOW_TRAP_EN
                    ovf_d       = ovf;
                    // Killing the control bundle suppresses writeback downstream
                    if (ovf) ctrl_d = 8'h00;
`endif
                end
            end
            MUL, DIV: begin
                if (md_done) begin
                    out_valid_d = 1'b1;
                    outd1_d     = d1_cap_q;
                    outd2_d     = md_lo;
                    ctrl_d      = ctrl_cap_q;
                    opmem_d     = op_cap_q;
                    hi_d        = md_hi;
                    lo_d        = md_lo;
                end
            end
            default: ;
        endcase
    end

    // Result, HI/LO and mul/div capture registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            outd1_q     <= '0;
            outd2_q     <= '0;
            ctrl_q      <= '0;
            opmem_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            d1_cap_q    <= '0;
            ctrl_cap_q  <= '0;
            op_cap_q    <= '0;
`ifdef OVERFLOW_TRAP_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            outd1_q     <= outd1_d;
            outd2_q     <= outd2_d;
            ctrl_q      <= ctrl_d;
            opmem_q     <= opmem_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
`ifdef OVERFLOW_TRAP_EN
            ovf_q       <= ovf_d;
`endif
            if (md_start) begin
                d1_cap_q   <= d1;
                ctrl_cap_q <= control_EX;
                op_cap_q   <= opcode;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign outd1       = outd1_q;
    assign outd2       = outd2_q;
    assign control_ALU = ctrl_q;
    assign opcode_mem  = opmem_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
`ifdef OVERFLOW_TRAP_EN
    assign ovf_trap    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed instruction sequence with a
// scoreboard of expected results checked whenever out_valid pulses.
module tb_alu_muldiv;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [7:0]   ctrl;
        logic [5:0]   op;
        logic         ovf;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [5:0]   opcode = '0;
    logic [5:0]   func = '0;
    logic [4:0]   shamt = '0;
    logic [15:0]  immediate = '0;
    logic [W-1:0] pc = 32'h1000;
    logic [W-1:0] d1 = '0;
    logic [W-1:0] d2 = '0;
    logic [7:0]   control_EX = '0;
    logic         out_valid;
    logic [W-1:0] outd1, outd2, hi, lo;
    logic [7:0]   control_ALU;
    logic [5:0]   opcode_mem;
`ifdef OVERFLOW_TRAP_EN
    logic         ovf_trap;
`endif

    int   n_assert = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    alu_muldiv #(
        .W (W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .func        (func),
        .shamt       (shamt),
        .immediate   (immediate),
        .pc          (pc),
        .d1          (d1),
        .d2          (d2),
        .control_EX  (control_EX),
        .out_valid   (out_valid),
        .outd1       (outd1),
        .outd2       (outd2),
        .control_ALU (control_ALU),
        .opcode_mem  (opcode_mem),
        .hi          (hi),
        .lo          (lo)
`ifdef OVERFLOW_TRAP_EN
        ,
        .ovf_trap    (ovf_trap)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected result
    always @(negedge clock) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("outd1", 64'(outd1), 64'(e.d1));
                chk("outd2", 64'(outd2), 64'(e.d2));
                chk("control_ALU", 64'(control_ALU), 64'(e.ctrl));
                chk("opcode_mem", 64'(opcode_mem), 64'(e.op));
`ifdef OVERFLOW_TRAP_EN
                chk("ovf_trap", 64'(ovf_trap), 64'(e.ovf));
`endif
            end
        end
    end

    // Wait (bounded) for in_ready, drive one instruction, push its expected result
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e1, input logic [W-1:0] e2,
                         input logic kill = 1'b0, input logic eovf = 1'b0);
        int   n = 0;
        exp_t e;
        @(negedge clock);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("issue_ready", 64'(in_ready), 64'd1);
        opcode     = op;
        func       = fn;
        shamt      = sh;
        immediate  = imm;
        d1         = a;
        d2         = b;
        control_EX = 8'($urandom);
        in_valid   = 1'b1;
        e.d1   = e1;
        e.d2   = e2;
        e.ctrl = kill ? 8'h00 : control_EX;
        e.op   = op;
        e.ovf  = eovf;
        sb_q.push_back(e);
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outd2", 64'(outd2), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // add 7 + -3 with latency 1
        issue(OP_RTYPE, FN_ADD, 0, 0, 32'd7, 32'hFFFF_FFFD, 32'd7, 32'd4);
        @(negedge clock);
        chk("add_latency", 64'(out_valid), 64'd1);
        issue(OP_RTYPE, FN_SLT, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1);
        issue(OP_RTYPE, FN_SLTU, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        // back-to-back issue
        issue(OP_RTYPE, FN_XOR, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(OP_RTYPE, FN_SUB, 0, 0, 32'd5, 32'd7, 32'd5, 32'hFFFF_FFFE);
        issue(OP_RTYPE, FN_SRA, 4, 0, 32'h11, 32'h8000_0010, 32'h11, 32'hF800_0001);
        issue(OP_RTYPE, FN_SLLV, 0, 0, 32'd36, 32'd3, 32'd36, 32'h30);
        issue(OP_RTYPE, FN_NOR, 0, 0, 32'h0F0F_0000, 32'h00FF_00FF, 32'h0F0F_0000, 32'hF000_FF00);
        issue(OP_RTYPE, FN_SLL, 0, 0, 32'd5, 32'd6, 32'd0, 32'd0);

        // mult -6 * 7: busy for W+1 cycles
        issue(OP_RTYPE, FN_MULT, 0, 0, 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6);
        cnt = 0;
        @(negedge clock);
        while (in_ready !== 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clock);
        end
        chk("mult_busy_cycles", 64'(cnt), 64'd33);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFD6);
        issue(OP_RTYPE, FN_MFLO, 0, 0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFD6);
        issue(OP_RTYPE, FN_MFHI, 0, 0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF);

        // Signed divides
        issue(OP_RTYPE, FN_DIV, 0, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFD);
        wait_idle();
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        issue(OP_RTYPE, FN_DIV, 0, 0, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFFD);
        wait_idle();
        chk("div2_hi", 64'(hi), 64'd1);
        issue(OP_RTYPE, FN_DIV, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000);
        wait_idle();
        chk("divmin_lo", 64'(lo), 64'h8000_0000);
        chk("divmin_hi", 64'(hi), 64'd0);
        issue(OP_RTYPE, FN_MULTU, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        wait_idle();
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'd1);

        // divu by zero: out_valid two cycles after accept
        issue(OP_RTYPE, FN_DIVU, 0, 0, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        @(negedge clock);
        chk("div0_cycle1", 64'(out_valid), 64'd0);
        @(negedge clock);
        chk("div0_cycle2", 64'(out_valid), 64'd1);
        chk("div0_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(hi), 64'd7);

        // I-type, memory, jump and unknown encodings
        issue(OP_ORI, 6'd0, 0, 16'h8000, 32'd0, 32'd9, 32'd0, 32'h0000_8000);
        issue(OP_ADDI, 6'd0, 0, 16'h8000, 32'd0, 32'd9, 32'd0, 32'hFFFF_8000);
        issue(OP_LW, 6'd0, 0, 16'hFFFC, 32'd100, 32'hDEAD, 32'hDEAD, 32'd96);
        issue(OP_SLTIU, 6'd0, 0, 16'hFFFF, 32'd5, 32'd0, 32'd5, 32'd1);
        issue(OP_ANDI, 6'd0, 0, 16'h8001, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'h0000_8001);
        issue(OP_LUI, 6'd0, 0, 16'h1234, 32'd3, 32'd0, 32'd3, 32'h1234_0000);
        pc = 32'h400;
        issue(OP_JAL, 6'd0, 0, 16'h0, 32'd8, 32'd9, 32'd8, 32'h404);
        issue(6'b111111, 6'd0, 0, 16'h0, 32'hAAAA_0001, 32'h5555_0002,
              32'hAAAA_0001, 32'h5555_0002);
`ifdef OVERFLOW_TRAP_EN
        issue(OP_RTYPE, FN_ADD, 0, 0, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000,
              1'b1, 1'b1);
        issue(OP_RTYPE, FN_ADDU, 0, 0, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000);
`endif

        // Reset in the middle of a multiply aborts it
        issue(OP_RTYPE, FN_MULT, 0, 0, 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6);
        repeat (5) @(negedge clock);
        chk("pre_rst_busy", 64'(in_ready), 64'd0);
        #1 reset = 1'b0;
        #1;
        sb_q.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_outd1", 64'(outd1), 64'd0);
        chk("midrst_outd2", 64'(outd2), 64'd0);
        chk("midrst_ctrl", 64'(control_ALU), 64'd0);
        chk("midrst_opmem", 64'(opcode_mem), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("postrst_ready", 64'(in_ready), 64'd1);
        issue(OP_RTYPE, FN_OR, 0, 0, 32'h0F00, 32'h00F0, 32'h0F00, 32'h0FF0);

        wait_idle();
        repeat (3) @(negedge clock);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised-width, registered execute-stage ALU for the MIPS pipeline; sits between ID/EX and EX/MEM.
- Replaces the combinational ALU path with a 1-cycle registered result.
- Adds an iterative multiply/divide unit with HI/LO registers and a valid/ready handshake, so EX can stall the front end.

Parameters:
- W, 32, datapath width; even, >= 16.
- SHW, $clog2(W), shift-amount width (derived; do not override).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  issue strobe from ID/EX
- in_ready  out  1  unit can accept an instruction this cycle
- opcode  in  6  instruction opcode
- func  in  6  R-type function field
- shamt  in  SHW  shift amount
- immediate  in  16  I-type immediate
- pc  in  W  PC of the issuing instruction
- d1  in  W  rs operand
- d2  in  W  rt operand
- control_EX  in  8  control bundle, passed through
- out_valid  out  1  result valid (one-cycle pulse per accepted instruction)
- outd1  out  W  secondary result (store data / rs pass-through)
- outd2  out  W  primary result / effective address
- control_ALU  out  8  captured control_EX
- opcode_mem  out  6  captured opcode
- hi, lo  out  W each  HI/LO architectural registers

Behaviour:
- Reset (reset==0, async): state IDLE, all outputs 0, hi=lo=0, counter 0. Reset mid-mul/div aborts the operation; hi/lo read 0.
- State machine: IDLE, MUL, DIV, DONE.
  - in_ready=1 only in IDLE.
  - Accept = in_valid & in_ready.
- Single-cycle ops: accepted in IDLE; outd1/outd2/control_ALU/opcode_mem registered; out_valid=1 on the next edge. Latency 1, throughput 1 per cycle.
- R-type functions:
  - add/addu/sub/subu: wrap modulo 2^W.
  - and, or, xor, nor.
  - slt: signed compare; sltu: unsigned compare; result 1/0 zero-extended.
  - sll/srl/sra: shift d2 by shamt; sra is arithmetic.
  - sllv/srlv/srav: shift d2 by d1[SHW-1:0].
  - func=000000 with shamt=0 (NOP): outd1=outd2=0.
  - mfhi: outd2=hi; mflo: outd2=lo.
  - For all of the above except NOP: outd1=d1.
- I-type:
  - addi/addiu/slti/sltiu: immediate sign-extended to W. sltiu compares unsigned after sign extension.
  - andi/ori/xori: immediate zero-extended.
  - lui: outd2 = {immediate, 16'b0} zero-extended to W.
- Memory ops lw/sw: outd2 = d1 + sext(imm) (effective address); outd1 = d2 (store data).
- beq/bne/j: outd1=d1, outd2=d2.
- jal: outd2 = pc+4.
- Unknown opcode/func: outd1=d1, outd2=d2. No latched or undefined output.
- mult/multu (func 011000/011001): IDLE→MUL. Radix-2 shift-add on magnitudes for exactly W cycles, then DONE.
  - Signed: result negated if operand signs differ.
  - {hi,lo} = 2W-bit product.
- div/divu (011010/011011): IDLE→DIV. Restoring division for W cycles, then DONE.
  - Signed: quotient sign = sign(d1)^sign(d2); remainder sign = sign(d1).
  - lo = quotient, hi = remainder.
  - MIN/-1: lo=MIN, hi=0.
  - d2==0: skip iteration (IDLE→DONE next edge); lo = all ones, hi = d1.
- DONE: hi/lo are updated on the edge entering DONE. In DONE: out_valid=1, outd1=d1 (captured), outd2=lo, control_ALU=captured control. Next edge →IDLE.
- Total mul/div latency: W+1 cycles from accept to out_valid (divide-by-zero: 2).
- in_valid while in_ready=0: ignored. The upstream stage holds the instruction.
- out_valid=0 in all other cycles. outd1/outd2 hold their last value.

Optional Feature:
- OVERFLOW_TRAP_EN defined:
  - Extra output ovf_trap (1 bit, reset 0), pulsed with out_valid on signed overflow of add, sub, or addi.
  - On overflow, control_ALU is forced to 8'h00 so no writeback occurs.
  - addu/subu/addiu never trap.
- Undefined: the port is absent; add/sub/addi wrap silently.

Decomposition:
- Shared package alu_pkg:
  - opcode and func localparams: OP_RTYPE, OP_ADDI, …, FN_ADD, FN_MULT, FN_MFHI, …
  - state enum {IDLE, MUL, DIV, DONE}.
  - sext16/zext16 functions.
- Sub-module muldiv_iter (parametrised by W): owns MUL/DIV iteration, the counter, sign fix-up and divide-by-zero handling. Interface: start, is_div, is_signed, a, b → done, hi_res, lo_res.

Test Plan:
- Reset low mid-MUL (cycle 5) → all outputs, hi and lo read 0 immediately; in_ready=1 after release.
- add d1=7, d2=-3 → out_valid next cycle, outd2=4. slt d1=-1, d2=1 → 1; sltu same operands → 0.
- mult d1=-6, d2=7 (W=32) → in_ready low for 33 cycles; hi=32'hFFFFFFFF, lo=32'hFFFFFFD6; then mflo → outd2=-42.
- div d1=-7, d2=2 → lo=-3, hi=-1. divu d1=7, d2=0 → lo=32'hFFFFFFFF, hi=7, out_valid 2 cycles after accept.
- ori imm=16'h8000, d1=0 → outd2=32'h00008000. addi imm=16'h8000, d1=0 → 32'hFFFF8000. lw d1=100, imm=-4 → outd2=96.
- With OVERFLOW_TRAP_EN: add 32'h7FFFFFFF + 1 → ovf_trap=1, control_ALU=0. addu with the same operands → no trap, outd2=32'h80000000.
